// File: rtl/ym2149_bus_master.sv
// ym2149_bus_master: buffers PSG register read/write requests in a FIFO and
// plays them out as BDIR/BC address-latch, write and read bus cycles.
module ym2149_bus_master #(
    parameter int FIFO_DEPTH = 8,
    parameter int HOLD       = 1,
    parameter int GAP        = 1,
    parameter bit ADDR_CACHE = 1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_rd,
    input  logic [7:0]                    req_addr,
    input  logic [7:0]                    req_data,
    output logic                          rsp_valid,
    output logic [7:0]                    rsp_data,
    output logic                          BDIR,
    output logic                          BC,
    output logic [7:0]                    DOUT,
    input  logic [7:0]                    DIN,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } req_t;

    typedef enum logic [2:0] {IDLE, LATCH, LGAP, ACCESS, AGAP} state_t;

    // ---------------- request FIFO ----------------
    req_t        mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        push, pop, empty, full;
    req_t        head;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level     = wr_ptr - rd_ptr;
    // Ready comes only from registered pointers, so a same-cycle pop never
    // reopens a full FIFO.
    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign head      = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since the pointers gate them.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= '{rd: req_rd, addr: req_addr, data: req_data};
    end

    // FIFO pointer update.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- bus sequencer ----------------
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    req_t          cur, cur_nxt;
    logic          last, done, hit;
    logic          cache_vld;
    logic [7:0]    last_addr;

    assign hit  = ADDR_CACHE && cache_vld && (head.addr == last_addr);
    assign busy = !empty || (state != IDLE);

    // Marks the final cycle of the current phase.
    always_comb begin
        last = 1'b1;
        case (state)
            LATCH, ACCESS: last = (cnt == CW'(HOLD - 1));
            LGAP, AGAP:    last = (cnt == CW'(GAP - 1));
            default:       last = 1'b1;
        endcase
    end

    // Next state and pop. The end of a transaction makes the IDLE decision in
    // the same cycle, so a queued request follows with exactly GAP idle cycles.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        pop       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    done = 1'b1;
            LATCH:   if (last) state_nxt = (GAP > 0) ? LGAP : ACCESS;
            LGAP:    if (last) state_nxt = ACCESS;
            ACCESS:  if (last) begin
                         if (GAP > 0) state_nxt = AGAP;
                         else         done = 1'b1;
                     end
            AGAP:    if (last) done = 1'b1;
            default: state_nxt = IDLE;
        endcase
        if (done) begin
            state_nxt = IDLE;
            if (!empty) begin
                pop       = 1'b1;
                cur_nxt   = head;
                state_nxt = hit ? ACCESS : LATCH;
            end
        end
    end

    // State, phase counter and current request registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            cur   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= last ? '0 : cnt + 1'b1;
            cur   <= cur_nxt;
        end
    end

    // Bus pins are registered from the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            BDIR <= 1'b0;
            BC   <= 1'b0;
            DOUT <= 8'h00;
        end else begin
            BDIR <= 1'b0;
            BC   <= 1'b0;
            DOUT <= 8'h00;
            case (state_nxt)
                LATCH: begin
                    BDIR <= 1'b1;
                    BC   <= 1'b1;
                    DOUT <= cur_nxt.addr;
                end
                ACCESS: begin
                    if (cur_nxt.rd) begin
                        BC <= 1'b1;
                    end else begin
                        BDIR <= 1'b1;
                        DOUT <= cur_nxt.data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address cache: remembers the last completed latch. Starts invalid since
    // the PSG's own reset value must not be assumed.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cache_vld <= 1'b0;
            last_addr <= 8'h00;
        end else if (state == LATCH && last) begin
            cache_vld <= 1'b1;
            last_addr <= cur.addr;
        end
    end

    // Read capture on the final ACCESS cycle; strobe for one cycle after.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            if (state == ACCESS && last && cur.rd) begin
                rsp_valid <= 1'b1;
                rsp_data  <= DIN;
            end
        end
    end

endmodule

// File: tb/tb_ym2149_bus_master.sv
// tb_ym2149_bus_master: three parameter sets driven with directed then random
// requests, compared every cycle against a transaction-schedule model.
module tb_ym2149_bus_master;
    localparam int NCFG = 3;
    localparam int NCYC = 1500;
    localparam int NA   = NCYC + 100;
    localparam int NDIR = 14;

    logic CLK = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int cfg, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, tag, got, exp);
        end
    endtask

    // Value the fake PSG presents on DIN during a given cycle.
    function automatic logic [7:0] din_of(input int c);
        return 8'((c * 7) ^ 8'hA5);
    endfunction

    // Directed opening: {rd, addr, data}
    function automatic logic [16:0] dir_req(input int i);
        case (i)
            0:       return {1'b0, 8'h0D, 8'h0E};
            1:       return {1'b0, 8'h07, 8'h38};
            2:       return {1'b1, 8'h07, 8'h00};
            12:      return {1'b1, 8'h0E, 8'h00};
            13:      return {1'b0, 8'h0E, 8'h55};
            default: return {1'b0, 8'(i - 3), 8'(8'h10 + i)};
        endcase
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int H  = (g == 0) ? 1 : (g == 1) ? 2 : 3;
        localparam int G  = (g == 0) ? 1 : (g == 1) ? 0 : 2;
        localparam int D  = (g == 0) ? 8 : (g == 1) ? 4 : 2;
        localparam bit AC = (g != 2);
        localparam int LW = $clog2(D) + 1;

        logic          RESET, req_valid, req_ready, req_rd, rsp_valid, BDIR, BC, busy;
        logic [7:0]    req_addr, req_data, rsp_data, DOUT, DIN;
        logic [LW-1:0] level;

        ym2149_bus_master #(.FIFO_DEPTH(D), .HOLD(H), .GAP(G), .ADDR_CACHE(AC)) dut (
            .CLK(CLK), .RESET(RESET),
            .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
            .req_addr(req_addr), .req_data(req_data),
            .rsp_valid(rsp_valid), .rsp_data(rsp_data),
            .BDIR(BDIR), .BC(BC), .DOUT(DOUT), .DIN(DIN),
            .busy(busy), .level(level)
        );

        // Expected per-cycle bus value {BDIR,BC,DOUT}, response, activity, pops.
        logic [9:0] e_bus  [NA];
        bit         e_rv   [NA];
        logic [7:0] e_rdat [NA];
        bit         e_act  [NA];
        bit         e_pop  [NA];
        int         free_at;
        bit         cv;
        logic [7:0] la;

        // Lay an accepted request out on the timeline: first active phase at
        // T+2 or right after the previous transaction, whichever is later.
        task automatic schedule(input int t, input logic rd, input logic [7:0] a, input logic [7:0] d);
            int k;
            k = (t + 2 > free_at) ? t + 2 : free_at;
            e_pop[k - 1] = 1'b1;
            if (!(AC && cv && la == a)) begin
                for (int i = 0; i < H; i++) begin e_bus[k] = {2'b11, a}; e_act[k] = 1'b1; k++; end
                for (int i = 0; i < G; i++) begin e_act[k] = 1'b1; k++; end
                cv = 1'b1;
                la = a;
            end
            for (int i = 0; i < H; i++) begin
                e_bus[k] = rd ? {2'b01, 8'h00} : {2'b10, d};
                e_act[k] = 1'b1;
                k++;
            end
            if (rd) begin
                e_rv[k]   = 1'b1;
                e_rdat[k] = din_of(k - 1);
            end
            for (int i = 0; i < G; i++) begin e_act[k] = 1'b1; k++; end
            free_at = k;
        endtask

        initial begin
            int         lvl, di;
            bit         push_ok, rst_now;
            logic [7:0] rsp_hold;
            logic [16:0] dr;
            for (int i = 0; i < NA; i++) begin
                e_bus[i] = '0; e_rv[i] = 1'b0; e_rdat[i] = '0; e_act[i] = 1'b0; e_pop[i] = 1'b0;
            end
            lvl = 0; di = 0; free_at = 0; cv = 1'b0; la = '0; rsp_hold = '0;
            RESET = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_addr = '0; req_data = '0; DIN = '0;
            repeat (2) @(posedge CLK);
            for (int c = 0; c < NCYC; c++) begin
                #1;
                DIN     = din_of(c);
                rst_now = (di >= NDIR) && (c < NCYC - 100) && ($urandom_range(0, 119) == 0);
                RESET   = rst_now;
                if (rst_now || c >= NCYC - 100) begin
                    req_valid = 1'b0;
                end else if (di < NDIR) begin
                    dr = dir_req(di);
                    {req_rd, req_addr, req_data} = dr;
                    req_valid = 1'b1;
                end else begin
                    req_valid = ($urandom_range(0, 3) != 0);
                    req_rd    = ($urandom_range(0, 2) == 0);
                    req_addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
                    req_data  = 8'($urandom);
                end
                @(negedge CLK);
                if (e_rv[c]) rsp_hold = e_rdat[c];
                chk("bdir_bc",   g, 32'({BDIR, BC}), 32'(e_bus[c][9:8]));
                chk("dout",      g, 32'(DOUT),       32'(e_bus[c][7:0]));
                chk("rsp_valid", g, 32'(rsp_valid),  32'(e_rv[c]));
                chk("rsp_data",  g, 32'(rsp_data),   32'(rsp_hold));
                chk("level",     g, 32'(level),      32'(lvl));
                chk("req_ready", g, 32'(req_ready),  32'(lvl != D));
                chk("busy",      g, 32'(busy),       32'((lvl > 0) || e_act[c]));
                if (rst_now) begin
                    lvl = 0; free_at = c + 1; cv = 1'b0; rsp_hold = '0;
                    for (int i = c + 1; i < NA; i++) begin
                        e_bus[i] = '0; e_rv[i] = 1'b0; e_act[i] = 1'b0; e_pop[i] = 1'b0;
                    end
                end else begin
                    push_ok = req_valid && (lvl != D);
                    if (push_ok) begin
                        schedule(c, req_rd, req_addr, req_data);
                        if (di < NDIR) di++;
                    end
                    lvl = lvl + int'(push_ok) - int'(e_pop[c]);
                end
                @(posedge CLK);
            end
            done_cnt++;
        end
    end

    initial begin
        wait (done_cnt == NCFG);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
